// File: rtl/rotate_frame_ctrl.sv
// rotate_frame_ctrl
//   Frame sequencer for the square RGB rotation datapath. One frame arrives
//   on a valid/ready stream and is written row-major into a single-port
//   SRAM. It is then read back in rotated raster order (0/90/180/270 cw)
//   and sent out on a valid/ready stream. A 2-entry skid buffer hides the
//   1-cycle SRAM read latency and absorbs output backpressure.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start_i, rot_i        begin a frame / rotation select, both sampled in IDLE
//   in_valid_i/in_data_i/in_ready_o      input pixel stream, x fastest
//   out_valid_o/out_data_o/out_ready_i   output pixel stream
//   out_eol_o, out_last_o                end of output row / end of frame
//   busy_o, done_o        frame in progress / one-cycle completion pulse
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i   SRAM port
module rotate_frame_ctrl #(
  parameter int DIM_LOG2 = 8,
  parameter int ADDR_SZ  = 20,
  parameter int PIX_W    = 24,
  parameter int MEM_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         rot_i,
  input  logic               in_valid_i,
  input  logic [PIX_W-1:0]   in_data_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  output logic [PIX_W-1:0]   out_data_o,
  input  logic               out_ready_i,
  output logic               out_eol_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [ADDR_SZ-1:0] mem_addr_o,
  output logic [MEM_W-1:0]   mem_wdata_o,
  input  logic [MEM_W-1:0]   mem_rdata_i
);

  localparam int AW = 2 * DIM_LOG2;

  typedef logic [DIM_LOG2-1:0] crd_t;
  localparam crd_t CMAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] d;
    logic             eol;
    logic             last;
  } ent_t;

  state_t     state_q, state_d;
  crd_t       wx_q, wx_d, wy_q, wy_d;
  crd_t       rx_q, rx_d, ry_q, ry_d;
  logic [1:0] rot_q, rot_d;
  logic       rd_all_q, rd_all_d;

  logic       rd_vld_p1_q;
  logic       rd_eol_p1_q;
  logic       rd_last_p1_q;

  ent_t       sk0_q, sk1_q;
  logic [1:0] cnt_q;

  logic          pop;
  logic [1:0]    occ;
  logic          rd_issue;
  logic [AW-1:0] addr_lo;
  ent_t          rd_ent;
  logic          unused_rdata;

  // N-1-c is the bitwise complement of a DIM_LOG2-bit coordinate.
  function automatic logic [AW-1:0] src_addr(input logic [1:0] r,
                                             input crd_t ox, input crd_t oy);
    logic [AW-1:0] a;
    case (r)
      2'd0:    a = {oy, ox};
      2'd1:    a = {~ox, oy};
      2'd2:    a = {~oy, ~ox};
      default: a = {ox, ~oy};
    endcase
    return a;
  endfunction

  assign pop = (cnt_q != 2'd0) && out_ready_i;
  // Occupancy counted after this cycle's pop so a steady stream keeps
  // issuing one read per cycle without ever exceeding two entries.
  assign occ = cnt_q + {1'b0, rd_vld_p1_q} - {1'b0, pop};
  assign rd_issue = (state_q == S_DRAIN) && !rd_all_q && (occ < 2'd2);

  always_comb begin
    state_d  = state_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    rot_d    = rot_q;
    rd_all_d = rd_all_q;
    mem_en_o = 1'b0;
    mem_we_o = 1'b0;
    addr_lo  = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_LOAD;
          rot_d    = rot_i;
          wx_d     = '0;
          wy_d     = '0;
          rx_d     = '0;
          ry_d     = '0;
          rd_all_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
          mem_en_o = 1'b1;
          mem_we_o = 1'b1;
          addr_lo  = {wy_q, wx_q};
          wx_d     = wx_q + 1'b1;
          if (wx_q == CMAX) wy_d = wy_q + 1'b1;
          if (wx_q == CMAX && wy_q == CMAX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_issue) begin
          mem_en_o = 1'b1;
          addr_lo  = src_addr(rot_q, rx_q, ry_q);
          rx_d     = rx_q + 1'b1;
          if (rx_q == CMAX) ry_d = ry_q + 1'b1;
          if (rx_q == CMAX && ry_q == CMAX) rd_all_d = 1'b1;
        end
        if (pop && sk0_q.last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == S_LOAD);
  assign busy_o      = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign mem_addr_o  = ADDR_SZ'(addr_lo);
  assign mem_wdata_o = MEM_W'(in_data_i);

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = sk0_q.d;
  assign out_eol_o   = out_valid_o && sk0_q.eol;
  assign out_last_o  = out_valid_o && sk0_q.last;

  assign rd_ent       = '{d: mem_rdata_i[PIX_W-1:0], eol: rd_eol_p1_q, last: rd_last_p1_q};
  assign unused_rdata = ^mem_rdata_i[MEM_W-1:PIX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wx_q     <= '0;
      wy_q     <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rot_q    <= '0;
      rd_all_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      rot_q    <= rot_d;
      rd_all_q <= rd_all_d;
    end
  end

  // Stage p1: read issued last cycle, SRAM data arrives this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1_q  <= 1'b0;
      rd_eol_p1_q  <= 1'b0;
      rd_last_p1_q <= 1'b0;
    end else begin
      rd_vld_p1_q  <= rd_issue;
      rd_eol_p1_q  <= (rx_q == CMAX);
      rd_last_p1_q <= (rx_q == CMAX) && (ry_q == CMAX);
    end
  end

  // Stage p2: skid buffer, sk0 is the head presented on the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk0_q <= '0;
      sk1_q <= '0;
      cnt_q <= '0;
    end else begin
      if (rd_vld_p1_q && pop) begin
        if (cnt_q == 2'd2) begin
          sk0_q <= sk1_q;
          sk1_q <= rd_ent;
        end else begin
          sk0_q <= rd_ent;
        end
      end else if (rd_vld_p1_q) begin
        if (cnt_q == 2'd0) sk0_q <= rd_ent;
        else               sk1_q <= rd_ent;
        cnt_q <= cnt_q + 2'd1;
      end else if (pop) begin
        sk0_q <= sk1_q;
        cnt_q <= cnt_q - 2'd1;
      end
    end
  end

endmodule
